// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply (MUL/MULHU) and restoring divide (DIVU/REMU).
// The divide datapath exists only when MULDIV_DIV_EN is defined; otherwise op 1x returns err.
module muldiv_unit #(
    parameter int unsigned RD_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [31:0]     rs1_data,
    input  logic [31:0]     rs2_data,
    input  logic [RD_W-1:0] rd_in,
    output logic            busy,
    output logic            done,
    output logic [31:0]     result,
    output logic [RD_W-1:0] rd_out,
    output logic            we,
    output logic            err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
`ifdef MULDIV_DIV_EN
        DIV  = 2'd2,
`endif
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [63:0]     acc_q, acc_d;
    logic [31:0]     opnd_q, opnd_d;
    logic            hi_sel_q, hi_sel_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [31:0]     result_q, result_d;
    logic [RD_W-1:0] rd_out_q, rd_out_d;
    logic            we_q, we_d;
    logic            err_q, err_d;

    logic [32:0]     mul_sum;
    logic [63:0]     mul_step;
    logic            last_iter;

    // Shift-add: acc = {partial product, remaining multiplier bits}.
    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        mul_step = {mul_sum, acc_q[31:1]};
    end

`ifdef MULDIV_DIV_EN
    logic [32:0] div_trial;
    logic [63:0] div_step;

    // Restoring divide: acc = {remainder, dividend/quotient}; quotient bits shift in at bit 0.
    always_comb begin
        div_trial = acc_q[63:31] - {1'b0, opnd_q};
        div_step  = div_trial[32] ? {acc_q[62:0], 1'b0}
                                  : {div_trial[31:0], acc_q[30:0], 1'b1};
    end
`endif

    assign last_iter = (cnt_q == 6'd31);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        hi_sel_d = hi_sel_q;
        rd_d     = rd_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    hi_sel_d = op[0];
                    rd_d     = rd_in;
                    cnt_d    = '0;
                    if (!op[1]) begin
                        state_d = MUL;
                        acc_d   = {32'd0, rs2_data};
                        opnd_d  = rs1_data;
                    end else begin
`ifdef MULDIV_DIV_EN
                        acc_d  = {32'd0, rs1_data};
                        opnd_d = rs2_data;
                        if (rs2_data == '0) begin
                            state_d  = DONE;
                            result_d = op[0] ? rs1_data : '1;
                            rd_out_d = rd_in;
                            err_d    = 1'b0;
                        end else begin
                            state_d = DIV;
                        end
`else
                        state_d  = DONE;
                        result_d = '0;
                        rd_out_d = rd_in;
                        err_d    = 1'b1;
`endif
                    end
                end
            end
            MUL: begin
                acc_d = mul_step;
                cnt_d = cnt_q + 6'd1;
                if (last_iter) begin
                    state_d  = DONE;
                    result_d = hi_sel_q ? mul_step[63:32] : mul_step[31:0];
                    rd_out_d = rd_q;
                    err_d    = 1'b0;
                end
            end
`ifdef MULDIV_DIV_EN
            DIV: begin
                acc_d = div_step;
                cnt_d = cnt_q + 6'd1;
                if (last_iter) begin
                    state_d  = DONE;
                    result_d = hi_sel_q ? div_step[63:32] : div_step[31:0];
                    rd_out_d = rd_q;
                    err_d    = 1'b0;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        we_d   = (state_d == DONE) && (rd_out_d != '0) && !err_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            hi_sel_q <= 1'b0;
            rd_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            hi_sel_q <= hi_sel_d;
            rd_q     <= rd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
            we_q     <= we_d;
            err_q    <= err_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign rd_out = rd_out_q;
    assign we     = we_q;
    assign err    = err_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: RD_W, 4, destination register index width; matches the 16-entry register file.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request strobe; sampled only in IDLE.
REQ-005 SHALL have port: op  input  2  operation: 00 MUL (low 32 bits), 01 MULHU (high 32 bits, unsigned), 10 DIVU, 11 REMU.
REQ-006 SHALL have port: rs1_data  input  32  operand A, taken from register file read_data_1.
REQ-007 SHALL have port: rs2_data  input  32  operand B, taken from register file read_data_2.
REQ-008 SHALL have port: rd_in  input  RD_W  destination register index for the result.
REQ-009 SHALL have port: busy  output  1  high while an operation is in flight.
REQ-010 SHALL have port: done  output  1  one-cycle pulse when result is valid.
REQ-011 SHALL have port: result  output  32  operation result, held until the next accepted start.
REQ-012 SHALL have port: rd_out  output  RD_W  captured destination index.
REQ-013 SHALL have port: we  output  1  register file write enable; equals done AND (rd_out != 0).
REQ-014 SHALL have port: err  output  1  high together with done when the requested op is not supported.

Function
REQ-015 SHALL implement FSM states IDLE, MUL, DIV, DONE; DONE lasts exactly one cycle and then returns to IDLE.
REQ-016 SHALL, in IDLE with start=1, capture op, rs1_data, rs2_data and rd_in, clear the iteration counter, and enter MUL (op 0x) or DIV (op 1x).
REQ-017 SHALL ignore start in MUL, DIV and DONE; captured operands SHALL NOT change until the operation completes.
REQ-018 SHALL compute MUL/MULHU by radix-2 shift-add over a 64-bit accumulator in exactly 32 iterations, one per cycle.
REQ-019 SHALL compute DIVU/REMU by restoring division in exactly 32 iterations, one per cycle, producing a 32-bit quotient and a 32-bit remainder.
REQ-020 SHALL use a 6-bit iteration counter and enter DONE on the cycle after the 32nd iteration.
REQ-021 SHALL assert done in the 33rd cycle after the start-accepting edge for normal operations.
REQ-022 SHALL assert busy from the cycle after start is accepted through the done cycle inclusive.
REQ-023 SHALL, for DIVU/REMU with rs2_data=0, bypass iteration and go directly to DONE, with done asserted 1 cycle after acceptance, DIVU result=0xFFFFFFFF, and REMU result=rs1_data.
REQ-024 SHALL leave result, rd_out and err unchanged outside DONE, and SHALL update them on the edge that enters DONE.
REQ-025 SHALL hold we low whenever rd_out=0, so that register zero is never written.
REQ-026 SHALL allow a new start in the IDLE cycle immediately following DONE, with no dead cycle.

Reset
REQ-027 SHALL, on reset low, immediately force state=IDLE, busy=0, done=0, we=0, err=0, result=0, rd_out=0, and counter=0, including mid-operation.
REQ-028 SHALL ignore start while reset is low; the first start is accepted on the first rising edge after reset deasserts.

Configuration
REQ-029 SHALL compile the DIV datapath and state only when macro MULDIV_DIV_EN is defined.
REQ-030 SHALL, without MULDIV_DIV_EN, answer op 10/11 by going directly to DONE, with done asserted 1 cycle after acceptance, result=0, err=1, and we forced to 0; MUL/MULHU SHALL be unaffected.
REQ-031 SHALL, with MULDIV_DIV_EN defined, never assert err.

Verification
REQ-032 SHALL verify: MUL 7 x 6, rd_in=5 -> done at cycle 33, result=0x0000002A, rd_out=5, we=1.
REQ-033 SHALL verify: MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE; MUL with the same operands -> result=0x00000001.
REQ-034 SHALL verify: DIVU 100/7 -> result=14; REMU 100/7 -> result=2; DIVU 5/0 -> result=0xFFFFFFFF with done 1 cycle after start; REMU 5/0 -> result=5.
REQ-035 SHALL verify: start pulsed with different operands at cycle 10 of a MUL -> ignored; original result returned at cycle 33.
REQ-036 SHALL verify: reset pulled low at cycle 15 of a DIVU -> busy=0 and result=0 immediately; a new MUL 3 x 3 after release -> result=9.
REQ-037 SHALL verify: rd_in=0 with MUL 2 x 2 -> done=1, result=4, we=0; without MULDIV_DIV_EN, DIVU -> done after 1 cycle, err=1, we=0.
